// File: rtl/stage_timing_pkg.sv
// Shared definitions for the stage timing harness.
//   state_e     - harness FSM states
//   LFSR_POLY   - Galois feedback taps shared by the stimulus lanes and the MISR
//   MISR_INIT   - signature value after reset and after every (re)start
//   SEED_STRIDE - golden-ratio stride that decorrelates per-lane seeds
//   lfsr_step   - one Galois shift, used by every lane and by the MISR
package stage_timing_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  localparam logic [31:0] LFSR_POLY   = 32'h8020_0003;
  localparam logic [31:0] MISR_INIT   = 32'hFFFF_FFFF;
  localparam logic [31:0] SEED_STRIDE = 32'h9E37_79B9;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/stage_lfsr.sv
// One 32-bit Galois LFSR stimulus lane.
//   clk_i    - clock
//   rst_ni   - asynchronous active-low reset, loads SeedVal
//   load_i   - reload SeedVal (has priority over enable_i)
//   enable_i - advance one step
//   lane_o   - the Width LSBs of the lane state
// The full 32-bit state always runs; only the visible slice is exported so a
// partially used top lane carries no dangling bits.
module stage_lfsr
  import stage_timing_pkg::*;
#(
  parameter int unsigned Width   = 32,
  parameter logic [31:0] SeedVal = 32'h0000_0001
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             enable_i,
  output logic [Width-1:0] lane_o
);

  logic [31:0] state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= SeedVal;
    end else if (load_i) begin
      state_q <= SeedVal;
    end else if (enable_i) begin
      state_q <= lfsr_step(state_q);
    end
  end

  assign lane_o = state_q[Width-1:0];

endmodule

// File: rtl/stage_timing_harness.sv
// Stimulus/response harness for closing timing on a single pipeline stage.
// Drives the stage input bus from per-lane Galois LFSRs, compacts the stage
// output bus into a 32-bit MISR, and reports a stable signature once the run
// and the drain window are over.
//   clk_i           - clock
//   rst_ni          - asynchronous active-low reset
//   start_i         - start/restart pulse, honoured in IDLE or DONE only
//   dut_in_o        - stimulus bus (lane concatenation, truncated)
//   dut_valid_o     - stimulus valid (RUN only)
//   dut_ready_i     - stage accepts stimulus (ignored when Handshake = 0)
//   dut_out_i       - stage result bus
//   dut_out_valid_i - result qualifier
//   busy_o          - RUN or DRAIN
//   done_o          - signature final
//   signature_o     - MISR state
//   cycle_count_o   - cycles spent in RUN + DRAIN, saturating
module stage_timing_harness
  import stage_timing_pkg::*;
#(
  parameter int unsigned InWidth     = 32,
  parameter int unsigned OutWidth    = 32,
  parameter int unsigned RunLength   = 1024,
  parameter int unsigned DrainCycles = 8,
  parameter logic [31:0] Seed        = 32'h0000_0001,
  parameter bit          Handshake   = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  output logic [InWidth-1:0]  dut_in_o,
  output logic                dut_valid_o,
  input  logic                dut_ready_i,
  input  logic [OutWidth-1:0] dut_out_i,
  input  logic                dut_out_valid_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [31:0]         signature_o,
  output logic [31:0]         cycle_count_o
);

  localparam int unsigned Lanes     = (InWidth + 31) / 32;
  localparam int unsigned OutChunks = (OutWidth + 31) / 32;
  localparam logic [31:0] LastBeat  = 32'(RunLength - 1);
  localparam logic [31:0] LastDrain = (DrainCycles == 0) ? 32'd0 : 32'(DrainCycles - 1);

  state_e      state_q;
  logic [31:0] beat_q;
  logic [31:0] drain_q;
  logic [31:0] misr_q;
  logic [31:0] cycle_q;
  logic        valid_q;
  logic        busy_q;
  logic        done_q;

  logic        advance;
  logic        reload;
  logic        in_window;

  // In free-run mode every RUN cycle is an accepted beat.
  assign advance   = (state_q == StRun) && (Handshake ? dut_ready_i : 1'b1);
  assign reload    = start_i && ((state_q == StIdle) || (state_q == StDone));
  assign in_window = (state_q == StRun) || (state_q == StDrain);

  // Stimulus lanes. Lane k owns dut_in_o[32k +: 32]; the top lane may be narrower.
  for (genvar k = 0; k < Lanes; k++) begin : g_lane
    localparam int unsigned LaneLsb  = 32 * k;
    localparam int unsigned LaneW    = ((InWidth - LaneLsb) >= 32) ? 32 : (InWidth - LaneLsb);
    localparam logic [31:0] RawSeed  = Seed ^ (32'(k) * SEED_STRIDE);
    localparam logic [31:0] LaneSeed = (RawSeed == 32'h0) ? 32'h1 : RawSeed;

    stage_lfsr #(
      .Width  (LaneW),
      .SeedVal(LaneSeed)
    ) u_lane (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (reload),
      .enable_i(advance),
      .lane_o  (dut_in_o[LaneLsb +: LaneW])
    );
  end

  // Zero-pad the result bus to whole 32-bit chunks and XOR the chunks together.
  logic [OutChunks*32-1:0] out_pad;
  logic [31:0]             fold;

  always_comb begin
    out_pad                 = '0;
    out_pad[OutWidth-1:0]   = dut_out_i;
    fold                    = '0;
    for (int unsigned c = 0; c < OutChunks; c++) begin
      fold = fold ^ out_pad[c*32 +: 32];
    end
  end

  // Control FSM with registered status outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      beat_q  <= '0;
      drain_q <= '0;
      misr_q  <= MISR_INIT;
      cycle_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // Capture also covers the edge that moves RUN/DRAIN into DONE.
      if (in_window) begin
        if (cycle_q != 32'hFFFF_FFFF) begin
          cycle_q <= cycle_q + 32'd1;
        end
        if (dut_out_valid_i) begin
          misr_q <= lfsr_step(misr_q) ^ fold;
        end
      end

      case (state_q)
        StIdle, StDone: begin
          // A restart in DONE discards any coincident result.
          if (start_i) begin
            state_q <= StRun;
            beat_q  <= '0;
            drain_q <= '0;
            misr_q  <= MISR_INIT;
            cycle_q <= '0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        StRun: begin
          if (advance) begin
            beat_q <= beat_q + 32'd1;
            if (beat_q == LastBeat) begin
              valid_q <= 1'b0;
              if (DrainCycles == 0) begin
                state_q <= StDone;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                state_q <= StDrain;
              end
            end
          end
        end
        StDrain: begin
          if (drain_q == LastDrain) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + 32'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dut_valid_o   = valid_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign signature_o   = misr_q;
  assign cycle_count_o = cycle_q;

endmodule

// File: tb/tb_stage_timing_harness.sv
// Bench for stage_timing_harness: a table-driven handshake run on a 32-bit
// instance (stall, drain, capture-on-final-edge, restart discard), a mid-DRAIN
// asynchronous reset followed by a bit-exact rerun, and a free-running 70-bit
// instance with start pulses during the run.
module tb_stage_timing_harness;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: InWidth 32, OutWidth 64, RunLength 4, DrainCycles 2, handshake.
  logic        rst_a_n, start_a, ready_a, ov_a;
  logic [63:0] out_a;
  logic [31:0] din_a, sig_a, cnt_a;
  logic        valid_a, busy_a, done_a;

  stage_timing_harness #(
    .InWidth    (32),
    .OutWidth   (64),
    .RunLength  (4),
    .DrainCycles(2),
    .Seed       (32'h0000_0001),
    .Handshake  (1'b1)
  ) u_dut_a (
    .clk_i          (clk),
    .rst_ni         (rst_a_n),
    .start_i        (start_a),
    .dut_in_o       (din_a),
    .dut_valid_o    (valid_a),
    .dut_ready_i    (ready_a),
    .dut_out_i      (out_a),
    .dut_out_valid_i(ov_a),
    .busy_o         (busy_a),
    .done_o         (done_a),
    .signature_o    (sig_a),
    .cycle_count_o  (cnt_a)
  );

  // Instance B: InWidth 70 (3 lanes), free-run, ready tied low, no drain.
  logic        rst_b_n, start_b;
  logic        ready_b = 1'b0;
  logic        ov_b    = 1'b0;
  logic [31:0] out_b   = 32'h0;
  logic [69:0] din_b;
  logic [31:0] sig_b, cnt_b;
  logic        valid_b, busy_b, done_b;

  stage_timing_harness #(
    .InWidth    (70),
    .OutWidth   (32),
    .RunLength  (16),
    .DrainCycles(0),
    .Seed       (32'h0000_0001),
    .Handshake  (1'b0)
  ) u_dut_b (
    .clk_i          (clk),
    .rst_ni         (rst_b_n),
    .start_i        (start_b),
    .dut_in_o       (din_b),
    .dut_valid_o    (valid_b),
    .dut_ready_i    (ready_b),
    .dut_out_i      (out_b),
    .dut_out_valid_i(ov_b),
    .busy_o         (busy_b),
    .done_o         (done_b),
    .signature_o    (sig_b),
    .cycle_count_o  (cnt_b)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference MISR/LFSR step and 64-bit fold.
  function automatic logic [31:0] ref_step(input logic [31:0] s);
    logic [31:0] fb;
    fb = s[0] ? 32'h8020_0003 : 32'h0;
    return (s >> 1) ^ fb;
  endfunction

  function automatic logic [31:0] ref_fold64(input logic [63:0] d);
    return d[31:0] ^ d[63:32];
  endfunction

  // Inputs applied before an edge, expected outputs after that edge.
  typedef struct {
    logic        start;
    logic        ready;
    logic        ov;
    logic [63:0] out;
    logic [31:0] e_din;
    logic        e_valid;
    logic        e_busy;
    logic        e_done;
    logic [31:0] e_cnt;
  } vec_t;

  localparam int NumVec = 12;
  vec_t        tbl [NumVec];
  logic [31:0] golden_sig;

  function automatic vec_t mk(input logic st, input logic rd, input logic ov,
                              input logic [63:0] out, input logic [31:0] din,
                              input logic v, input logic b, input logic d,
                              input logic [31:0] cnt);
    vec_t r;
    r.start = st; r.ready = rd; r.ov = ov; r.out = out;
    r.e_din = din; r.e_valid = v; r.e_busy = b; r.e_done = d; r.e_cnt = cnt;
    return r;
  endfunction

  task automatic run_table(input int pass);
    logic [31:0] m;
    logic        prev_busy;
    m         = 32'hFFFF_FFFF;
    prev_busy = 1'b0;
    for (int i = 0; i < NumVec; i++) begin
      start_a = tbl[i].start;
      ready_a = tbl[i].ready;
      ov_a    = tbl[i].ov;
      out_a   = tbl[i].out;
      if (tbl[i].start && !prev_busy) begin
        m = 32'hFFFF_FFFF;
      end else if (tbl[i].ov && prev_busy) begin
        m = ref_step(m) ^ ref_fold64(tbl[i].out);
      end
      @(posedge clk);
      #1;
      check($sformatf("p%0d r%0d din", pass, i), din_a, tbl[i].e_din);
      check($sformatf("p%0d r%0d valid", pass, i), valid_a, tbl[i].e_valid);
      check($sformatf("p%0d r%0d busy", pass, i), busy_a, tbl[i].e_busy);
      check($sformatf("p%0d r%0d done", pass, i), done_a, tbl[i].e_done);
      check($sformatf("p%0d r%0d cycles", pass, i), cnt_a, tbl[i].e_cnt);
      check($sformatf("p%0d r%0d sig", pass, i), sig_a, m);
      if (i == 2) check($sformatf("p%0d fold_zero_sig", pass), sig_a, 32'hFFDF_FFFC);
      if (i == 9) begin
        if (pass == 0) golden_sig = m;
        else check("golden_rerun", sig_a, golden_sig);
      end
      prev_busy = tbl[i].e_busy;
    end
    start_a = 1'b0;
    ov_a    = 1'b0;
  endtask

  initial begin
    //               st    rdy   ov    out                     din           v     b     d     cnt
    tbl[0]  = mk(1'b1, 1'b1, 1'b0, 64'h0,                  32'h0000_0001, 1'b1, 1'b1, 1'b0, 32'd0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b0, 64'h0,                  32'h8020_0003, 1'b1, 1'b1, 1'b0, 32'd1);
    tbl[2]  = mk(1'b0, 1'b1, 1'b1, 64'h0000_0001_0000_0001, 32'hC030_0002, 1'b1, 1'b1, 1'b0, 32'd2);
    tbl[3]  = mk(1'b0, 1'b0, 1'b0, 64'h0,                  32'hC030_0002, 1'b1, 1'b1, 1'b0, 32'd3);
    tbl[4]  = mk(1'b1, 1'b0, 1'b0, 64'h0,                  32'hC030_0002, 1'b1, 1'b1, 1'b0, 32'd4);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 64'h0,                  32'hC030_0002, 1'b1, 1'b1, 1'b0, 32'd5);
    tbl[6]  = mk(1'b0, 1'b1, 1'b0, 64'h0,                  32'h6018_0001, 1'b1, 1'b1, 1'b0, 32'd6);
    tbl[7]  = mk(1'b0, 1'b1, 1'b1, 64'h1234_5678_0000_00FF, 32'hB02C_0003, 1'b0, 1'b1, 1'b0, 32'd7);
    tbl[8]  = mk(1'b0, 1'b1, 1'b1, 64'h0000_0000_8000_0000, 32'hB02C_0003, 1'b0, 1'b1, 1'b0, 32'd8);
    tbl[9]  = mk(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_0000_0000, 32'hB02C_0003, 1'b0, 1'b0, 1'b1, 32'd9);
    tbl[10] = mk(1'b0, 1'b0, 1'b1, 64'h5555_5555_5555_0000, 32'hB02C_0003, 1'b0, 1'b0, 1'b1, 32'd9);
    tbl[11] = mk(1'b1, 1'b0, 1'b1, 64'hAAAA_0000_0000_AAAA, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 32'd0);

    rst_a_n = 1'b0; rst_b_n = 1'b0;
    start_a = 1'b0; ready_a = 1'b0; ov_a = 1'b0; out_a = 64'h0;
    start_b = 1'b0;
    golden_sig = 32'h0;
    #12;
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    #1;

    // Reset values.
    check("a_rst din", din_a, 32'h0000_0001);
    check("a_rst valid", valid_a, 1'b0);
    check("a_rst busy", busy_a, 1'b0);
    check("a_rst done", done_a, 1'b0);
    check("a_rst sig", sig_a, 32'hFFFF_FFFF);
    check("a_rst cycles", cnt_a, 32'd0);
    check("b_rst lane0", din_b[31:0], 32'h0000_0001);
    check("b_rst lane1", din_b[63:32], 32'h9E37_79B8);
    check("b_rst lane2", din_b[69:64], 6'h33);
    check("b_rst valid", valid_b, 1'b0);

    // Instance A, first pass: ends restarted in RUN with no beats taken.
    run_table(0);

    // Four accepted beats with captures, leaving the FSM in its first DRAIN cycle.
    ready_a = 1'b1;
    ov_a    = 1'b1;
    out_a   = 64'hDEAD_BEEF_0000_0001;
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst busy", busy_a, 1'b1);
    check("pre_rst valid", valid_a, 1'b0);
    check("pre_rst done", done_a, 1'b0);
    #2;
    rst_a_n = 1'b0;
    #1;
    check("mid_rst din", din_a, 32'h0000_0001);
    check("mid_rst valid", valid_a, 1'b0);
    check("mid_rst busy", busy_a, 1'b0);
    check("mid_rst done", done_a, 1'b0);
    check("mid_rst sig", sig_a, 32'hFFFF_FFFF);
    check("mid_rst cycles", cnt_a, 32'd0);
    ov_a    = 1'b0;
    ready_a = 1'b0;
    #2;
    rst_a_n = 1'b1;
    @(posedge clk);
    #1;

    // Same stimulus again must reproduce the golden signature.
    run_table(1);

    // Instance B: free-run, 16 RUN cycles, start pulses ignored.
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    check("b_start valid", valid_b, 1'b1);
    check("b_start busy", busy_b, 1'b1);
    check("b_start lane2", din_b[69:64], 6'h33);
    for (int i = 1; i <= 16; i++) begin
      start_b = (i == 3) || (i == 10);
      @(posedge clk);
      #1;
      if (i == 1) begin
        check("b_step1 lane0", din_b[31:0], 32'h8020_0003);
        check("b_step1 lane2", din_b[69:64], 6'h3A);
      end
      if (i < 16) begin
        check($sformatf("b_run%0d busy", i), busy_b, 1'b1);
        check($sformatf("b_run%0d done", i), done_b, 1'b0);
      end else begin
        check("b_end done", done_b, 1'b1);
        check("b_end busy", busy_b, 1'b0);
        check("b_end valid", valid_b, 1'b0);
        check("b_end cycles", cnt_b, 32'd16);
      end
    end
    start_b = 1'b0;
    @(posedge clk);
    #1;
    check("b_hold done", done_b, 1'b1);
    check("b_hold cycles", cnt_b, 32'd16);
    check("b_hold sig", sig_b, 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
